// File: rtl/muldiv_if.sv
// muldiv_if: request and result bundle between the execute stage and muldiv_unit.
interface muldiv_if #(parameter int WIDTH = 32);
    logic             flush;
    logic             in_valid;
    logic [2:0]       op;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic [WIDTH-1:0] hi_in;
    logic [WIDTH-1:0] lo_in;
    logic             busy;
    logic             out_valid;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master (output flush, in_valid, op, srca, srcb, hi_in, lo_in, input busy, out_valid, hi, lo);
    modport slave (input flush, in_valid, op, srca, srcb, hi_in, lo_in, output busy, out_valid, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle HI/LO multiply/divide with a 2-cycle multiplier and a restoring divider.
// Define MULDIV_MADD_EN to build multiply-accumulate; otherwise ops 1xx run as plain MULT/MULTU.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic      clk,
    input logic      rst,
    muldiv_if.slave  bus
);
    localparam int W  = WIDTH;
    localparam int CW = $clog2(W) + 1;

    typedef enum logic [2:0] {IDLE, MUL, ACC, DIV, FIX, DONE} state_e;

    state_e         state_q, state_d, first_st;
    logic           busy_q, out_valid_q;
    logic [W-1:0]   a_q, b_q, rem_q, quo_q, den_q, hi_q, lo_q;
    logic           sgn_q, mac_q, negq_q, negr_q, dz_q;
    logic [CW-1:0]  cnt_q;
`ifdef MULDIV_MADD_EN
    logic           sub_q;
    logic [2*W-1:0] prod_q, acc_q;
`endif
    logic           accept, sgn, is_div, is_mac, a_neg, b_neg, dz;
    logic [W-1:0]   a_mag, b_mag;
    logic [2*W-1:0] prod;
    logic [W:0]     sh, diff;

    assign accept = bus.in_valid & ~busy_q & ~bus.flush;
    assign sgn    = ~bus.op[0];
    assign is_div = ~bus.op[2] & bus.op[1];
`ifdef MULDIV_MADD_EN
    assign is_mac = bus.op[2];
`else
    assign is_mac = 1'b0;
`endif
    assign a_neg    = sgn & bus.srca[W-1];
    assign b_neg    = sgn & bus.srcb[W-1];
    assign a_mag    = a_neg ? -bus.srca : bus.srca;
    assign b_mag    = b_neg ? -bus.srcb : bus.srcb;
    assign dz       = is_div & (bus.srcb == '0);
    assign first_st = dz ? FIX : is_div ? DIV : MUL;
    // Sign-extending to 2W and truncating gives the correct product for both signednesses.
    assign prod = {{W{sgn_q & a_q[W-1]}}, a_q} * {{W{sgn_q & b_q[W-1]}}, b_q};
    assign sh   = {rem_q, quo_q[W-1]};
    assign diff = sh - {1'b0, den_q};

    always_comb begin
        state_d = bus.flush ? IDLE :
                  accept ? first_st :
                  state_q == MUL ? (mac_q ? ACC : DONE) :
                  state_q == ACC ? DONE :
                  state_q == DIV ? (cnt_q == CW'(1) ? FIX : DIV) :
                  state_q == FIX ? DONE : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= state_d inside {MUL, ACC, DIV, FIX};
            out_valid_q <= state_d == DONE;
            if (accept) begin
                a_q    <= bus.srca;
                b_q    <= bus.srcb;
                sgn_q  <= sgn;
                mac_q  <= is_mac;
                dz_q   <= dz;
                negq_q <= a_neg ^ b_neg;
                negr_q <= a_neg;
                rem_q  <= '0;
                quo_q  <= a_mag;
                den_q  <= b_mag;
                cnt_q  <= CW'(W);
`ifdef MULDIV_MADD_EN
                sub_q  <= bus.op[1];
                acc_q  <= {bus.hi_in, bus.lo_in};
`endif
            end else if (!bus.flush) begin
                case (state_q)
                    MUL: begin
`ifdef MULDIV_MADD_EN
                        if (mac_q) prod_q <= prod;
                        else {hi_q, lo_q} <= prod;
`else
                        {hi_q, lo_q} <= prod;
`endif
                    end
`ifdef MULDIV_MADD_EN
                    ACC: {hi_q, lo_q} <= sub_q ? acc_q - prod_q : acc_q + prod_q;
`endif
                    DIV: begin
                        rem_q <= diff[W] ? sh[W-1:0] : diff[W-1:0];
                        quo_q <= {quo_q[W-2:0], ~diff[W]};
                        cnt_q <= cnt_q - CW'(1);
                    end
                    FIX: begin
                        hi_q <= dz_q ? a_q : negr_q ? -rem_q : rem_q;
                        lo_q <= dz_q ? '1 : negq_q ? -quo_q : quo_q;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
endmodule
